// File: rtl/xadc_filter_pkg.sv
// Shared constants and FSM encoding for the XADC moving-average filter.
package xadc_filter_pkg;
  localparam int DATA_W = 12;
  localparam int CH_W   = 2;
  localparam int NUM_CH = 4;

  // DRP addresses of the aux channels feeding filter channels 0..3
  localparam logic [NUM_CH-1:0][6:0] DRP_AUX_ADDR = {7'h16, 7'h1F, 7'h17, 7'h1E};

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_UPDATE,
    ST_OUT
  } state_e;
endpackage

// File: rtl/xadc_avg_filter_ram.sv
// Single-port sample store, one-cycle registered read, no reset (zeroed by the CLEAR sweep).
module avg_sample_ram #(
  parameter int AW = 6,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/xadc_avg_filter.sv
// Four-channel boxcar average over the last 2**LOG2_N samples per channel,
// sharing one sample RAM and one add/subtract path.
module xadc_avg_filter
  import xadc_filter_pkg::*;
#(
  parameter int LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0] primed
);
  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;
  localparam int AW    = CH_W + LOG2_N;
  localparam logic [LOG2_N:0] FILL_FULL = N[LOG2_N:0];

  if (LOG2_N < 1 || LOG2_N > 6) begin : g_bad_log2n
    $error("xadc_avg_filter: LOG2_N must be in 1..6");
  end

  state_e state_q, state_d;
  logic [AW-1:0]                         clr_q, clr_d;
  logic [CH_W-1:0]                       ch_q, ch_d;
  logic [DATA_W-1:0]                     data_q, data_d;
  logic [NUM_CH-1:0][SUM_W-1:0]          sum_q, sum_d;
  logic [NUM_CH-1:0][LOG2_N-1:0]         ptr_q, ptr_d;
  logic [NUM_CH-1:0][LOG2_N:0]           fill_q, fill_d;
  logic [NUM_CH-1:0]                     primed_q, primed_d;
  logic [CH_W-1:0]                       out_ch_q, out_ch_d;
  logic [DATA_W-1:0]                     out_data_q, out_data_d;

  logic              accept;
  logic [SUM_W-1:0]  sum_new;
  logic [LOG2_N:0]   fill_inc;
  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR:  if (clr_q == '1) state_d = ST_IDLE;
      ST_IDLE:   if (accept) state_d = ST_READ;
      ST_READ:   state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_OUT;
      ST_OUT:    state_d = ST_IDLE;
      default:   state_d = ST_CLEAR;
    endcase
  end

  // Outputs are forced to their reset values while rst is high, not just after the edge.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = (state_q == ST_OUT) && !rst;
    out_ch    = rst ? '0 : out_ch_q;
    out_data  = rst ? '0 : out_data_q;
    primed    = rst ? '0 : primed_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {ch_q, ptr_q[ch_q]};
    ram_wdata = data_q;
    case (state_q)
      ST_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_q;
        ram_wdata = '0;
      end
      ST_IDLE: begin
        ram_en   = accept;
        ram_addr = {in_ch, ptr_q[in_ch]};
      end
      ST_UPDATE: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Evicted sample was added earlier, so subtract-then-add cannot underflow.
  always_comb begin
    sum_new    = sum_q[ch_q] - SUM_W'(ram_rdata) + SUM_W'(data_q);
    fill_inc   = fill_q[ch_q] + (LOG2_N+1)'(1);
    clr_d      = (state_q == ST_CLEAR) ? clr_q + AW'(1) : '0;
    ch_d       = ch_q;
    data_d     = data_q;
    sum_d      = sum_q;
    ptr_d      = ptr_q;
    fill_d     = fill_q;
    primed_d   = primed_q;
    out_ch_d   = out_ch_q;
    out_data_d = out_data_q;
    if (state_q == ST_IDLE && accept) begin
      ch_d   = in_ch;
      data_d = in_data;
    end
    if (state_q == ST_UPDATE) begin
      sum_d[ch_q] = sum_new;
      ptr_d[ch_q] = ptr_q[ch_q] + LOG2_N'(1);
      if (fill_q[ch_q] != FILL_FULL) begin
        fill_d[ch_q] = fill_inc;
        if (fill_inc == FILL_FULL) primed_d[ch_q] = 1'b1;
      end
      out_ch_d   = ch_q;
      out_data_d = sum_new[SUM_W-1:LOG2_N];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q      <= '0;
      ch_q       <= '0;
      data_q     <= '0;
      sum_q      <= '0;
      ptr_q      <= '0;
      fill_q     <= '0;
      primed_q   <= '0;
      out_ch_q   <= '0;
      out_data_q <= '0;
    end else begin
      clr_q      <= clr_d;
      ch_q       <= ch_d;
      data_q     <= data_d;
      sum_q      <= sum_d;
      ptr_q      <= ptr_d;
      fill_q     <= fill_d;
      primed_q   <= primed_d;
      out_ch_q   <= out_ch_d;
      out_data_q <= out_data_d;
    end
  end

  avg_sample_ram #(.AW(AW), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );
endmodule

// File: doc/xadc_avg_filter.md
Name: xadc_avg_filter

Overview:
- Per-channel boxcar moving-average filter placed directly downstream of the XADC DRP readout.
- Consumes 12-bit conversion results (dout[15:4]) tagged with a 2-bit channel index; emits one averaged 12-bit result per accepted sample.
- Its output replaces raw XADC bytes as the source for the LED PWM duty registers: duty = out_data[11:4] for out_ch.
- Four channels share one sample RAM and one arithmetic path.

Parameters:
- LOG2_N, 4, log2 of window length N per channel; legal range 1..6.
- DATA_W, 12, sample width; fixed, taken from package.
- CH_W, 2, channel index width (4 channels); fixed, taken from package.

Ports:
- clk, in, 1, system clock (same clock as the XADC DRP).
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, sample available; upstream holds in_ch and in_data stable until accepted.
- in_ready, out, 1, filter can accept a sample; a sample is accepted when in_valid && in_ready at a clk edge.
- in_ch, in, CH_W, channel index of the sample (0..3).
- in_data, in, DATA_W, unsigned sample.
- out_valid, out, 1, one-cycle pulse; out_ch and out_data are valid in that cycle.
- out_ch, out, CH_W, channel of the result.
- out_data, out, DATA_W, averaged result.
- primed, out, 4, bit c = 1 once channel c has received at least N samples since reset.

Behaviour:
- Reset:
  - Any cycle with rst=1 forces state CLEAR and zeroes the per-channel sums (DATA_W+LOG2_N bits), write pointers (LOG2_N bits) and fill counters.
  - Outputs during and after reset: in_ready=0, out_valid=0, out_ch=0, out_data=0, primed=0.
  - Any in-flight sample is dropped and no out_valid is produced for it.
- CLEAR:
  - After rst deasserts, writes 0 to all 4*N RAM entries, one per cycle (4*N cycles), then goes to IDLE.
  - in_ready=0 throughout; in_valid is ignored.
- IDLE:
  - in_ready=1.
  - On accept: latch ch and data, issue RAM read at {ch, ptr[ch]}, go to READ.
- READ: wait one cycle for the synchronous RAM output, then go to UPDATE.
- UPDATE:
  - sum[ch] <= sum[ch] - old + new.
  - Write new to {ch, ptr[ch]}.
  - ptr[ch] <= ptr[ch]+1, wrapping from N-1 to 0.
  - Fill counter saturates at N; primed[ch] is set in the same cycle the counter reaches N.
  - Go to OUT.
- OUT:
  - out_valid=1, out_ch=ch, out_data = sum[ch] >> LOG2_N (truncating).
  - Next state is IDLE.
  - out_ch and out_data hold their value until the next OUT.
- Latency and throughput:
  - Accept at edge T gives out_valid high in the cycle after edge T+2 (3-cycle latency).
  - At most 1 sample per 4 cycles; in_ready is high only in IDLE.
- Arithmetic:
  - All values are unsigned.
  - The sum never overflows: max is N*4095 < 2^(DATA_W+LOG2_N).
  - The subtraction never underflows because old was previously added to the sum.
- Warm-up: RAM is zero-filled, so the first k<N outputs equal floor(sum/N) and ramp up. This is the required behaviour; there is no division by k.
- Channel independence: pointers, sums and fill counters are strictly per channel. A sample on one channel never changes another channel's state.
- Illegal LOG2_N: outside 1..6 is an elaboration error.

Decomposition:
- Package xadc_filter_pkg holds:
  - DATA_W=12, CH_W=2, NUM_CH=4.
  - XADC aux channel DRP addresses: 7'h1E, 7'h17, 7'h1F, 7'h16.
  - FSM state encoding: CLEAR, IDLE, READ, UPDATE, OUT.
- One sub-module, avg_sample_ram: single-port synchronous RAM with depth NUM_CH*2^LOG2_N, width DATA_W, 1-cycle read latency, write-first not required.

Test Plan:
- Reset/CLEAR: pulse rst for 1 cycle with in_valid=1 held high -> in_ready=0 for exactly 64 cycles (LOG2_N=4); no accepts; out_valid=0, out_data=0x000, primed=0x0; then in_ready=1.
- Ramp: 16 samples of 0xFFF on ch0 -> outputs 0x0FF, 0x1FF, ... floor(4095*k/16) for sample k; 16th output = 0xFFF; primed=0x1 after the 16th UPDATE.
- Interleave: alternate ch1=0x800 and ch2=0x100, 16 each -> each channel ramps independently to final 0x800 and 0x100; ch0/ch3 sums stay 0; primed=0x6.
- Wrap: after 16×0x400 on ch3, feed 16×0x000 on ch3 -> outputs 0x3C0, 0x380, ..., 0x040, 0x000; pointer wrap verified by the exact decrement of 0x40 per sample.
- Handshake/latency: in_valid held continuously with a new value after each accept -> exactly one accept per 4 cycles; out_valid 3 cycles after each accept edge; no lost or duplicated samples.
- Reset mid-op: assert rst while in READ after a 0x800 sample on ch0 -> no out_valid for that sample; after CLEAR, one 0x800 on ch0 gives out_data=0x080.
